// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the memory-mapped UART transmitter.
//   - tx_state_t     : serialiser FSM states
//   - REG_*          : register selectors (addr[3:2])
//   - ST_*           : bit positions inside the STATUS register
//   - pack_status()  : assembles the 32-bit STATUS read value
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 4;
   localparam int ST_COUNT_MSB = 7;

   function automatic logic [31:0] pack_status(input logic [3:0] count,
                                               input logic       ovf,
                                               input logic       empty,
                                               input logic       full,
                                               input logic       busy);
      logic [31:0] s;
      s                           = '0;
      s[ST_COUNT_MSB:ST_COUNT_LSB] = count;
      s[ST_OVF]                   = ovf;
      s[ST_EMPTY]                 = empty;
      s[ST_FULL]                  = full;
      s[ST_BUSY]                  = busy;
      return s;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_if
//   CPU data-memory port as seen by the UART (same WE/A/WD that go to dmem).
//   Signals:
//     we        : store strobe
//     addr      : byte address
//     wdata     : store data
//     rdata     : registered read data
//     dbg_state : serialiser FSM state, for observation only
//
//   Bus protocol: there is no valid/ready handshake and no backpressure.
//   we qualifies addr/wdata as a store on every rising edge it is high; the
//   slave never stalls. Every edge also performs an implicit read: rdata
//   after edge N holds the register addressed during cycle N (0 on a miss).
// -----------------------------------------------------------------------------
interface mmio_uart_tx_if;
   logic                 we;
   logic [31:0]          addr;
   logic [31:0]          wdata;
   logic [31:0]          rdata;
   uart_pkg::tx_state_t  dbg_state;

   modport master (output we, addr, wdata, input rdata, dbg_state);
   modport slave  (input we, addr, wdata, output rdata, dbg_state);
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO.
//   Ports:
//     clk, rst : clock, synchronous active-high reset (empties the FIFO)
//     push     : write din; accepted when not full or when popping same edge
//     pop      : consume dout; ignored when empty
//     din/dout : data in / head-of-queue data out (combinational from head)
//     full     : count == DEPTH
//     empty    : count == 0
//     count    : occupancy, $clog2(DEPTH)+1 bits
//   DEPTH must be a power of 2 and at least 2 so the pointers wrap for free.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A push into a full FIFO still fits if the head leaves on the same edge.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter sitting beside dmem on the CPU store
//   path. Stores to the 16-byte window at BASE_ADDR are decoded; TXDATA
//   stores enqueue bytes into a small FIFO drained by the serialiser.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : slave side of mmio_uart_tx_if (we/addr/wdata in, rdata out)
//     tx       : serial line, idles high, registered
//     tx_idle  : FIFO empty and serialiser idle
//   Registers (addr[3:2]):
//     0 TXDATA  W: push wdata[7:0]        R: 0
//     1 STATUS  R: {count, ovf, empty, full, busy}; W: wdata[3]=1 clears ovf
//     2 BAUDDIV RW: clocks per bit, 16 bits, 0 is stored as 1
//     3 reserved
// -----------------------------------------------------------------------------
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
   parameter int          FIFO_DEPTH   = 4,
   parameter int          CLKS_PER_BIT = 434
) (
   input  logic          clk,
   input  logic          rst,
   mmio_uart_tx_if.slave bus,
   output logic          tx,
   output logic          tx_idle
);

   localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_RST = 16'(CLKS_PER_BIT);

   // ---------------------------------------------------------------- decode
   logic       hit;
   logic [1:0] reg_sel;
   logic       wr_txdata, wr_status, wr_baud;

   assign hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign reg_sel   = bus.addr[3:2];
   assign wr_txdata = bus.we && hit && (reg_sel == REG_TXDATA);
   assign wr_status = bus.we && hit && (reg_sel == REG_STATUS);
   assign wr_baud   = bus.we && hit && (reg_sel == REG_BAUDDIV);

   // Address bits below the word offset and the upper store data are unused.
   logic unused_bits;
   assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

   // ------------------------------------------------------------------ FIFO
   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .din   (bus.wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ------------------------------------------------------------- registers
   logic [15:0] baud_q, baud_d;
   logic        ovf_q, ovf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ovf_set;

   // The FIFO drops the byte only if it is full and nothing leaves this edge.
   assign ovf_set = wr_txdata && fifo_full && !fifo_pop;

   // ------------------------------------------------------------------- FSM
   tx_state_t   state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] div_q, div_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        tx_q, tx_d;
   logic        bit_done;

   assign tx_idle = fifo_empty && (state_q == IDLE);
   assign bit_done = (baud_cnt_q == div_q - 16'd1);

   // Register file: writes, overflow flag and the always-on read mux.
   always_comb begin
      baud_d  = baud_q;
      ovf_d   = ovf_q;
      rdata_d = '0;
      if (wr_baud) begin
         baud_d = (bus.wdata[15:0] == 16'd0) ? 16'd1 : bus.wdata[15:0];
      end
      if (wr_status && bus.wdata[ST_OVF]) ovf_d = 1'b0;
      // Set after clear so a simultaneous overflow keeps the flag.
      if (ovf_set) ovf_d = 1'b1;
      if (hit) begin
         case (reg_sel)
            REG_STATUS:  rdata_d = pack_status(4'(fifo_count), ovf_q,
                                               fifo_empty, fifo_full, !tx_idle);
            REG_BAUDDIV: rdata_d = {16'd0, baud_q};
            default:     rdata_d = '0;
         endcase
      end
   end

   // Serialiser next-state. Each state lasts div_q cycles counted by
   // baud_cnt_q; div_q is sampled from BAUDDIV only when a frame starts.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      div_d      = div_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      fifo_pop   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_d    = fifo_dout;
               div_d      = baud_q;
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               state_d    = START;
            end
         end
         START: begin
            if (bit_done) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_done) begin
               baud_cnt_d = '0;
               shift_d    = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) state_d = STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         STOP: begin
            if (bit_done) begin
               baud_cnt_d = '0;
               // Chain straight into the next frame so there is no idle gap.
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  shift_d   = fifo_dout;
                  div_d     = baud_q;
                  bit_idx_d = '0;
                  state_d   = START;
               end else begin
                  state_d   = IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
      endcase

      // tx is decoded from the next state so the line changes on the same
      // edge as the FSM, straight out of a flop.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         div_q      <= BAUD_RST;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         tx_q       <= 1'b1;
         baud_q     <= BAUD_RST;
         ovf_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         div_q      <= div_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         tx_q       <= tx_d;
         baud_q     <= baud_d;
         ovf_q      <= ovf_d;
         rdata_q    <= rdata_d;
      end
   end

   assign tx            = tx_q;
   assign bus.rdata     = rdata_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
   import uart_pkg::*;

   localparam logic [31:0] BASE     = 32'hFFFF0000;
   localparam logic [31:0] A_TXDATA = 32'hFFFF0000;
   localparam logic [31:0] A_STATUS = 32'hFFFF0004;
   localparam logic [31:0] A_BAUD   = 32'hFFFF0008;
   localparam logic [31:0] A_RSVD   = 32'hFFFF000C;
   localparam logic [31:0] A_MISS   = 32'h10010000;
   localparam int          DEPTH    = 4;

   // ------------------------------------------------------ clock / reset
   logic clk = 1'b0;
   logic rst;
   logic tx, tx_idle;
   always #5 clk = ~clk;

   mmio_uart_tx_if bus();

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (434)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .tx      (tx),
      .tx_idle (tx_idle)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------- scoreboard
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: byte queue, flags, and the per-cycle line levels of
   // the frame in flight (exp_q). A frame is just 10 bits each held m_baud
   // cycles; a new frame starts on any edge where no levels remain queued.
   logic [7:0]  fq[$];
   logic [0:0]  exp_q[$];
   logic [15:0] m_baud;
   logic        m_ovf;
   logic        m_in_frame;
   logic        exp_tx;
   logic [31:0] exp_rdata;

   // Inputs as seen by the DUT at each rising edge.
   logic        s_valid = 1'b0;
   logic        s_rst, s_we;
   logic [31:0] s_addr, s_wdata;

   always @(posedge clk) begin
      s_valid <= 1'b1;
      s_rst   <= rst;
      s_we    <= bus.we;
      s_addr  <= bus.addr;
      s_wdata <= bus.wdata;
   end

   task automatic model_step();
      logic        hit;
      logic [1:0]  sel;
      logic [31:0] rd;
      logic [7:0]  b;
      logic        drop;
      if (s_rst) begin
         fq.delete();
         exp_q.delete();
         m_baud     = 16'd434;
         m_ovf      = 1'b0;
         m_in_frame = 1'b0;
         exp_tx     = 1'b1;
         exp_rdata  = '0;
         return;
      end
      hit  = (s_addr[31:4] == BASE[31:4]);
      sel  = s_addr[3:2];
      rd   = '0;
      drop = 1'b0;
      if (hit && sel == 2'd1)
         rd = {24'd0, 4'(fq.size()), m_ovf, fq.size() == 0, fq.size() == DEPTH,
               m_in_frame || fq.size() != 0};
      if (hit && sel == 2'd2) rd = {16'd0, m_baud};
      if (exp_q.size() == 0 && fq.size() != 0) begin
         b = fq.pop_front();
         for (int k = 0; k < int'(m_baud); k++) exp_q.push_back(1'b0);
         for (int i = 0; i < 8; i++)
            for (int k = 0; k < int'(m_baud); k++) exp_q.push_back(b[i]);
         for (int k = 0; k < int'(m_baud); k++) exp_q.push_back(1'b1);
      end
      if (s_we && hit) begin
         case (sel)
            2'd0: if (fq.size() < DEPTH) fq.push_back(s_wdata[7:0]); else drop = 1'b1;
            2'd1: if (s_wdata[3]) m_ovf = 1'b0;
            2'd2: m_baud = (s_wdata[15:0] == 16'd0) ? 16'd1 : s_wdata[15:0];
            default: ;
         endcase
      end
      if (drop) m_ovf = 1'b1;
      if (exp_q.size() != 0) begin
         exp_tx     = exp_q.pop_front();
         m_in_frame = 1'b1;
      end else begin
         exp_tx     = 1'b1;
         m_in_frame = 1'b0;
      end
      exp_rdata = rd;
   endtask

   // Single compare process: every cycle, on the falling edge.
   always @(negedge clk) begin
      if (s_valid) begin
         model_step();
         check("tx", tx, exp_tx);
         check("tx_idle", tx_idle, (fq.size() == 0) && !m_in_frame);
         check("rdata", bus.rdata, exp_rdata);
      end
   end

   // ------------------------------------------------------ driver tasks
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.we    = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      @(negedge clk);
      bus.we    = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.we   = 1'b0;
      bus.addr = a;
      @(negedge clk);
      d = bus.rdata;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (tx_idle !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", tx_idle, 1'b1);
   endtask

   // ---------------------------------------------------------- stimulus
   initial begin
      logic [31:0] rd;
      logic [39:0] cap;
      logic [39:0] pat_a5, pat_55_0f;
      int          r;
      logic [31:0] a;

      pat_a5    = 40'b0000_1111_0000_1111_0000_0000_1111_0000_1111_1111;
      pat_55_0f = {20'b00110011001100110011, 20'b00111111110000000011};

      rst       = 1'b1;
      bus.we    = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("reset_tx", tx, 1'b1);
      check("reset_tx_idle", tx_idle, 1'b1);
      check("reset_state", bus.dbg_state, IDLE);
      bus_read(A_STATUS, rd);
      check("reset_status", rd, 32'h00000004);
      bus_read(A_BAUD, rd);
      check("reset_bauddiv", rd, 32'd434);

      // Single frame 0xA5 at 4 clocks per bit
      bus_write(A_BAUD, 32'd4);
      bus_write(A_TXDATA, 32'hA5);
      check("a5_idle_gap", tx, 1'b1);
      cap = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cap = {cap[38:0], tx};
      end
      check("a5_wave", cap, pat_a5);
      @(negedge clk);
      check("a5_idle_after", tx_idle, 1'b1);

      // Back-to-back frames 0x55, 0x0F at 2 clocks per bit
      bus_write(A_BAUD, 32'd2);
      bus_write(A_TXDATA, 32'h55);
      bus_write(A_TXDATA, 32'h0F);
      cap = '0;
      for (int i = 0; i < 40; i++) begin
         cap = {cap[38:0], tx};
         if (i == 0) bus.addr = A_STATUS;
         if (i == 1) check("b2b_status", bus.rdata, 32'h00000011);
         @(negedge clk);
      end
      check("b2b_wave", cap, pat_55_0f);
      wait_idle(10);

      // Overflow: six random bytes into a 4-deep FIFO at 100 clocks per bit
      bus_write(A_BAUD, 32'd100);
      for (int i = 0; i < 6; i++) bus_write(A_TXDATA, 32'($urandom_range(0, 255)));
      bus_read(A_STATUS, rd);
      check("ovf_status", rd, 32'h0000004B);
      bus_write(A_STATUS, 32'h8);
      bus_read(A_STATUS, rd);
      check("ovf_cleared", rd, 32'h00000043);
      wait_idle(6000);

      // Reset during data bit 3 aborts the frame and empties the FIFO
      bus_write(A_TXDATA, 32'h3C);
      bus_write(A_TXDATA, 32'hC3);
      repeat (450) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_tx", tx, 1'b1);
      check("abort_state", bus.dbg_state, IDLE);
      bus_read(A_STATUS, rd);
      check("abort_status", rd, 32'h00000004);
      repeat (200) @(negedge clk);
      check("abort_no_frame", tx, 1'b1);

      // Reserved / miss reads, BAUDDIV zero write, dmem-window stores
      bus_write(A_BAUD, 32'd0);
      bus_read(A_RSVD, rd);
      check("rsvd_read", rd, 32'd0);
      bus_read(A_MISS, rd);
      check("miss_read", rd, 32'd0);
      bus_read(A_BAUD, rd);
      check("baud_zero", rd, 32'd1);
      bus_read(A_TXDATA, rd);
      check("txdata_read", rd, 32'd0);
      bus_write(A_MISS, 32'h41);
      bus_write(A_MISS + 32'h10, 32'h42);
      bus_write(A_RSVD, 32'h43);
      bus_read(A_STATUS, rd);
      check("miss_no_push", rd, 32'h00000004);

      // Random traffic at short bit times
      bus_write(A_BAUD, 32'($urandom_range(1, 3)));
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 9);
         a = {BASE[31:4], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         case (r)
            0, 1, 2: bus_write({a[31:4], 2'd0, a[1:0]}, $urandom);
            3:       bus_write({a[31:4], 2'd1, a[1:0]}, $urandom);
            4:       bus_write({a[31:4], 2'd2, a[1:0]}, 32'($urandom_range(0, 3)));
            5:       bus_write(A_MISS + 32'($urandom_range(0, 63) * 4), $urandom);
            6:       bus_read(A_MISS + 32'($urandom_range(0, 63) * 4), rd);
            default: bus_read(a, rd);
         endcase
      end
      wait_idle(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
